// File: rtl/conv_result_writer.sv
// Result writer behind the MAC engine: buffers accumulator results in a small FIFO,
// requantises them to OUT_W bits and streams them into the output-feature RAM.
module conv_result_writer #(
  parameter int ACC_W      = 24,
  parameter int OUT_W      = 8,
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int SHIFT_W    = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        out_base,
  input  logic [ADDR_W-1:0]        out_count,
  input  logic [SHIFT_W-1:0]       shift,
  input  logic                     relu_en,
  input  logic                     calc_valid,
  input  logic signed [ACC_W-1:0]  calc_data,
  input  logic                     o_ready,
  output logic                     o_we,
  output logic [ADDR_W-1:0]        o_addr,
  output logic signed [OUT_W-1:0]  o_data,
  output logic                     busy,
  output logic                     fifo_full,
  output logic                     frame_done,
  output logic                     overflow
);

  localparam int XW    = ACC_W + 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FW    = PTR_W + 1;

  localparam logic signed [XW-1:0] SAT_MAX = XW'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [XW-1:0] SAT_MIN = XW'(-(1 << (OUT_W - 1)));

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state_q;
  logic [ADDR_W-1:0]         base_q;
  logic [ADDR_W-1:0]         count_q;
  logic [SHIFT_W-1:0]        shift_q;
  logic                      relu_q;
  logic [ADDR_W-1:0]         wr_idx_q;
  logic [ADDR_W-1:0]         wr_idx_d;

  logic signed [ACC_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q;
  logic [PTR_W-1:0]          rd_ptr_q;
  logic [FW-1:0]             fcnt_q;

  logic                      o_we_q;
  logic [ADDR_W-1:0]         o_addr_q;
  logic signed [OUT_W-1:0]   o_data_q;
  logic                      busy_q;
  logic                      frame_done_q;
  logic                      overflow_q;

  logic run, start_ok, wr_done, last_wr, fifo_empty, full, pop, push, drop;

  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [XW-1:0] x);
    if (x > SAT_MAX)      return OUT_W'(SAT_MAX);
    else if (x < SAT_MIN) return OUT_W'(SAT_MIN);
    else                  return OUT_W'(x);
  endfunction

  // ReLU, round-half-up, arithmetic shift; one guard bit keeps the rounding add from wrapping.
  function automatic logic signed [OUT_W-1:0] requant(input logic signed [ACC_W-1:0] d,
                                                      input logic                    relu,
                                                      input logic [SHIFT_W-1:0]      sh);
    logic signed [XW-1:0] x;
    logic signed [XW-1:0] rnd;
    x = XW'(d);
    if (relu && (x < 0)) x = '0;
    rnd = '0;
    if (sh != '0) rnd = XW'(1) << (sh - 1'b1);
    x = (x + rnd) >>> sh;
    return saturate(x);
  endfunction

  always_comb begin
    run        = (state_q == RUN);
    start_ok   = start && !run;
    fifo_empty = (fcnt_q == '0);
    full       = (fcnt_q == FW'(FIFO_DEPTH));
    wr_done    = o_we_q && o_ready;
    last_wr    = wr_done && (wr_idx_q == count_q - 1'b1);
    pop        = run && !fifo_empty && (!o_we_q || o_ready) && !last_wr;
    push       = run && calc_valid && (!full || pop);
    drop       = run && calc_valid && full && !pop && !last_wr;
    wr_idx_d   = wr_idx_q + {{(ADDR_W-1){1'b0}}, wr_done};
  end

  // Stage p0: result FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= calc_data;
  end

  // Stage p1: requantised result held at the RAM write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      base_q       <= '0;
      count_q      <= '0;
      shift_q      <= '0;
      relu_q       <= 1'b0;
      wr_idx_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fcnt_q       <= '0;
      o_we_q       <= 1'b0;
      o_addr_q     <= '0;
      o_data_q     <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (start_ok) begin
        base_q     <= out_base;
        count_q    <= out_count;
        shift_q    <= shift;
        relu_q     <= relu_en;
        wr_idx_q   <= '0;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        fcnt_q     <= '0;
        o_we_q     <= 1'b0;
        overflow_q <= 1'b0;
        if (out_count == '0) begin
          state_q      <= DONE;
          busy_q       <= 1'b0;
          frame_done_q <= 1'b1;
        end else begin
          state_q <= RUN;
          busy_q  <= 1'b1;
        end
      end else if (run) begin
        if (drop) overflow_q <= 1'b1;
        if (last_wr) begin
          state_q      <= DONE;
          busy_q       <= 1'b0;
          frame_done_q <= 1'b1;
          o_we_q       <= 1'b0;
          wr_idx_q     <= wr_idx_d;
          wr_ptr_q     <= '0;
          rd_ptr_q     <= '0;
          fcnt_q       <= '0;
        end else begin
          wr_idx_q <= wr_idx_d;
          if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
          if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
          if (push && !pop)      fcnt_q <= fcnt_q + 1'b1;
          else if (pop && !push) fcnt_q <= fcnt_q - 1'b1;
          if (pop) begin
            o_we_q   <= 1'b1;
            o_addr_q <= base_q + wr_idx_d;
            o_data_q <= requant(mem[rd_ptr_q], relu_q, shift_q);
          end else if (wr_done) begin
            o_we_q <= 1'b0;
          end
        end
      end
    end
  end

  assign o_we       = o_we_q;
  assign o_addr     = o_addr_q;
  assign o_data     = o_data_q;
  assign busy       = busy_q;
  assign fifo_full  = full;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule
